// File: rtl/sha256_block.sv
// sha256_block: single-block SHA-256 compression, one round per clock.
// Ports: clk, reset (async, active-high), start (sampled in IDLE),
//        h_block {H7..H0} chaining in, message {W0..W15} padded block,
//        h_out {H7'..H0'} result (held until next FINAL), done (1-cycle pulse).
module sha256_block #(
    parameter int NUM_ROUNDS = 64
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic [255:0] h_block,
    input  logic [511:0] message,
    output logic [255:0] h_out,
    output logic         done
);
    typedef enum logic [1:0] {IDLE, ROUND, FINAL} state_t;
    localparam logic [31:0] K [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };
    state_t      state;
    logic [31:0] w [16];
    logic [31:0] a, b, c, d, e, f, g, h;
    logic [255:0] hs;
    logic [6:0]  t;
    logic [31:0] t1, t2, w_new;
    function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction
    always_comb begin
        t1 = h + (rotr(e, 6) ^ rotr(e, 11) ^ rotr(e, 25)) + ((e & f) ^ (~e & g)) + K[t[5:0]] + w[0];
        t2 = (rotr(a, 2) ^ rotr(a, 13) ^ rotr(a, 22)) + ((a & b) ^ (a & c) ^ (b & c));
        w_new = (rotr(w[14], 17) ^ rotr(w[14], 19) ^ (w[14] >> 10)) + w[9]
              + (rotr(w[1], 7) ^ rotr(w[1], 18) ^ (w[1] >> 3)) + w[0];
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            done  <= 1'b0;
            h_out <= '0;
            t     <= '0;
            hs    <= '0;
            {h, g, f, e, d, c, b, a} <= '0;
            for (int i = 0; i < 16; i++) w[i] <= '0;
        end else begin
            done <= (state == FINAL);
            case (state)
                IDLE: if (start) begin
                    for (int i = 0; i < 16; i++) w[i] <= message[511 - 32*i -: 32];
                    {h, g, f, e, d, c, b, a} <= h_block;
                    hs    <= h_block;
                    t     <= '0;
                    state <= ROUND;
                end
                ROUND: begin
                    {h, g, f, e, d, c, b, a} <= {g, f, e, d + t1, c, b, a, t1 + t2};
                    for (int i = 0; i < 15; i++) w[i] <= w[i+1];
                    w[15] <= w_new;
                    t     <= t + 7'd1;
                    if (t == 7'(NUM_ROUNDS - 1)) state <= FINAL;
                end
                FINAL: begin
                    h_out <= {hs[255:224] + h, hs[223:192] + g, hs[191:160] + f, hs[159:128] + e,
                              hs[127:96] + d, hs[95:64] + c, hs[63:32] + b, hs[31:0] + a};
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_sha256_block.sv
// tb_sha256_block: directed digest, latency, busy-start, reset and input-hold checks for sha256_block.
module tb_sha256_block;
    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         start = 1'b0;
    logic [255:0] h_block = '0;
    logic [511:0] message = '0;
    logic [255:0] h_out;
    logic         done;
    int checks = 0;
    int failures = 0;
    int n, n2, cnt;
    logic [255:0] d1;
    sha256_block dut (
        .clk(clk), .reset(reset), .start(start), .h_block(h_block),
        .message(message), .h_out(h_out), .done(done)
    );
    always #5 clk = ~clk;
    // Digest text order H0..H7 -> port order {H7..H0}
    function automatic logic [255:0] wr(input logic [255:0] be);
        logic [255:0] r;
        for (int i = 0; i < 8; i++) r[32*i +: 32] = be[255 - 32*i -: 32];
        return r;
    endfunction
    localparam logic [255:0] IV_BE    = 256'h6a09e667bb67ae853c6ef372a54ff53a510e527f9b05688c1f83d9ab5be0cd19;
    localparam logic [255:0] ABC_BE   = 256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
    localparam logic [255:0] EMPTY_BE = 256'he3b0c44298fc1c149afbf4c8996fb92427ae41e4649b934ca495991b7852b855;
    localparam logic [255:0] CHAIN_BE = 256'h248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1;
    localparam logic [511:0] ABC_MSG   = {32'h61626380, 448'h0, 32'h00000018};
    localparam logic [511:0] EMPTY_MSG = {32'h80000000, 480'h0};
    localparam logic [511:0] CH1_MSG = {32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667,
                                        32'h65666768, 32'h66676869, 32'h6768696a, 32'h68696a6b,
                                        32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f,
                                        32'h6d6e6f70, 32'h6e6f7071, 32'h80000000, 32'h00000000};
    localparam logic [511:0] CH2_MSG = {480'h0, 32'h000001c0};
    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask
    task automatic start_block(input logic [511:0] msg, input logic [255:0] hb);
        message = msg;
        h_block = hb;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask
    // Counts edges after the start edge until done; mode 1 re-pulses start, mode 2 scrambles inputs.
    task automatic wait_done(input int mode, output int cycles);
        cycles = 0;
        for (int k = 1; k <= 80; k++) begin
            if (mode == 1) begin
                start = (k == 10 || k == 40);
                if (k >= 10) message = '1;
            end
            if (mode == 2) begin
                for (int j = 0; j < 16; j++) message[32*j +: 32] = $urandom;
                for (int j = 0; j < 8; j++) h_block[32*j +: 32] = $urandom;
            end
            @(posedge clk);
            #1;
            if (done) begin
                cycles = k;
                start = 1'b0;
                return;
            end
        end
        start = 1'b0;
    endtask
    initial begin
        repeat (2) @(posedge clk);
        #1;
        chk("reset_h_out", h_out, '0);
        chk("reset_done", 256'(done), 256'd0);
        reset = 1'b0;
        @(posedge clk);
        #1;
        start_block(ABC_MSG, wr(IV_BE));
        wait_done(0, n);
        chk("abc_latency", 256'(n), 256'd65);
        chk("abc_digest", h_out, wr(ABC_BE));
        @(posedge clk);
        #1;
        chk("done_single_cycle", 256'(done), 256'd0);
        start_block(EMPTY_MSG, wr(IV_BE));
        wait_done(0, n);
        chk("empty_latency", 256'(n), 256'd65);
        chk("empty_digest", h_out, wr(EMPTY_BE));
        @(posedge clk);
        #1;
        start_block(CH1_MSG, wr(IV_BE));
        wait_done(0, n);
        chk("chain1_latency", 256'(n), 256'd65);
        d1 = h_out;
        start_block(CH2_MSG, d1);
        wait_done(0, n2);
        chk("chain_done_spacing", 256'(n2 + 1), 256'd66);
        chk("chain_digest", h_out, wr(CHAIN_BE));
        @(posedge clk);
        #1;
        start_block(ABC_MSG, wr(IV_BE));
        wait_done(1, n);
        chk("busy_latency", 256'(n), 256'd65);
        chk("busy_digest", h_out, wr(ABC_BE));
        cnt = 0;
        for (int k = 0; k < 80; k++) begin
            @(posedge clk);
            #1;
            if (done) cnt++;
        end
        chk("busy_no_extra_done", 256'(cnt), 256'd0);
        start_block(EMPTY_MSG, wr(IV_BE));
        repeat (29) @(posedge clk);
        #1;
        reset = 1'b1;
        #1;
        chk("midreset_h_out", h_out, '0);
        chk("midreset_done", 256'(done), 256'd0);
        @(posedge clk);
        #1;
        chk("midreset_h_out_clocked", h_out, '0);
        reset = 1'b0;
        cnt = 0;
        for (int k = 0; k < 70; k++) begin
            @(posedge clk);
            #1;
            if (done) cnt++;
        end
        chk("midreset_no_stale_done", 256'(cnt), 256'd0);
        start_block(ABC_MSG, wr(IV_BE));
        wait_done(0, n);
        chk("postreset_latency", 256'(n), 256'd65);
        chk("postreset_digest", h_out, wr(ABC_BE));
        @(posedge clk);
        #1;
        start_block(EMPTY_MSG, wr(IV_BE));
        wait_done(2, n);
        chk("hold_latency", 256'(n), 256'd65);
        chk("hold_digest", h_out, wr(EMPTY_BE));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
